// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB arbiter: requester indices, sizing constants and the
// execute-stage write-back packet broadcast on the common data bus.
`ifndef FALSE
`define FALSE 1'b0
`endif

package cdb_arbiter_pkg;

  localparam int unsigned CDB_N_REQ = 4;
  localparam int unsigned ROB_TAG_W = 5;
  localparam int unsigned DATA_W    = 32;

  typedef enum logic [1:0] {
    CDB_REQ_ALU  = 2'd0,
    CDB_REQ_MEM  = 2'd1,
    CDB_REQ_LB   = 2'd2,
    CDB_REQ_MULT = 2'd3
  } CDB_REQ_IDX;

  typedef struct packed {
    logic                 valid;
    logic                 speculative;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [DATA_W-1:0]    value;
  } EX_WR_PACKET;

endpackage

// File: rtl/cdb_req_fifo.sv
// Per-requester result FIFO: in-order push/pop, kill compaction of speculative entries
// and resolve clearing of speculative bits. head_c/empty_c already reflect this edge's kill.
module cdb_req_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        kill,
  input  logic        resolve,
  input  logic        push_valid,
  input  EX_WR_PACKET push_packet,
  input  logic        pop,
  output EX_WR_PACKET head_c,
  output logic        empty_c,
  output logic        full_c
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  EX_WR_PACKET      entries_q [DEPTH];
  EX_WR_PACKET      entries_d [DEPTH];
  EX_WR_PACKET      surv      [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] surv_cnt;
  logic             push_ok;

  // Entries that outlive this edge's kill, packed toward the head in original order.
  always_comb begin : survivors
    int n;
    n = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      surv[i] = '0;
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if ((i < int'(count_q)) && !(kill && entries_q[i].speculative)) begin
        surv[IDX_W'(n)] = entries_q[i];
        n++;
      end
    end
    surv_cnt = CNT_W'(n);
  end

  assign head_c  = surv[0];
  assign empty_c = (surv_cnt == '0);
  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign push_ok = push_valid && !full_c && !(kill && push_packet.speculative);

  // Pop happens before push so a fresh packet can never be granted on its own push edge.
  always_comb begin : next_state
    int n;
    entries_d = surv;
    n         = int'(surv_cnt);
    if (pop && (n > 0)) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        entries_d[i] = entries_d[i + 1];
      end
      entries_d[DEPTH-1] = '0;
      n--;
    end
    if (push_ok && (n < int'(DEPTH))) begin
      entries_d[IDX_W'(n)] = push_packet;
      n++;
    end
    if (resolve) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_d[i].speculative = `FALSE;
      end
    end
    count_d = CNT_W'(n);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter draining per-requester FIFOs onto a registered common data bus.
// Optional CDB_ARB_STATS_EN adds saturating per-requester stall and grant counters.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = CDB_N_REQ,
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  EX_WR_PACKET [N_REQ-1:0]        req_packet,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic                           kill,
  input  logic                           resolve,
  output EX_WR_PACKET                    cdb_packet,
  output logic                           cdb_valid,
  output logic [$clog2(N_REQ)-1:0]       cdb_src
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [N_REQ-1:0][31:0]         stall_cycles,
  output logic [N_REQ-1:0][31:0]         grant_cycles
`endif
);

  localparam int unsigned SRC_W = $clog2(N_REQ);

  EX_WR_PACKET      head_c [N_REQ];
  logic [N_REQ-1:0] empty_c;
  logic [N_REQ-1:0] full_c;
  logic [N_REQ-1:0] pop;

  logic             grant_any;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W-1:0] cand;

  logic [SRC_W-1:0] rr_q, rr_d;
  logic             cdb_valid_q, cdb_valid_d;
  EX_WR_PACKET      cdb_packet_q, cdb_packet_d;
  logic [SRC_W-1:0] cdb_src_q, cdb_src_d;

  for (genvar g = 0; g < N_REQ; g++) begin : g_fifo
    cdb_req_fifo #(
      .DEPTH(DEPTH)
    ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .kill       (kill),
      .resolve    (resolve),
      .push_valid (req_valid[g]),
      .push_packet(req_packet[g]),
      .pop        (pop[g]),
      .head_c     (head_c[g]),
      .empty_c    (empty_c[g]),
      .full_c     (full_c[g])
    );
  end

  // Ready comes from registered occupancy only; a full FIFO stays not-ready while popping.
  assign req_ready = ~full_c;

  // First non-empty FIFO at or after the pointer, wrapping circularly.
  always_comb begin
    grant_any    = 1'b0;
    grant_idx    = '0;
    cand         = '0;
    pop          = '0;
    rr_d         = rr_q;
    cdb_valid_d  = 1'b0;
    cdb_packet_d = '0;
    cdb_src_d    = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      cand = SRC_W'((int'(rr_q) + k) % int'(N_REQ));
      if (!grant_any && !empty_c[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_any) begin
      pop[grant_idx]   = 1'b1;
      rr_d             = SRC_W'((int'(grant_idx) + 1) % int'(N_REQ));
      cdb_valid_d      = 1'b1;
      cdb_packet_d     = head_c[grant_idx];
      cdb_packet_d.valid = 1'b1;
      if (resolve) begin
        cdb_packet_d.speculative = `FALSE;
      end
      cdb_src_d        = grant_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q         <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_packet_q <= '0;
      cdb_src_q    <= '0;
    end else begin
      rr_q         <= rr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_packet_q <= cdb_packet_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_packet = cdb_packet_q;
  assign cdb_src    = cdb_src_q;

`ifdef CDB_ARB_STATS_EN
  localparam int unsigned STAT_W = 32;

  logic [N_REQ-1:0][STAT_W-1:0] stall_q, stall_d;
  logic [N_REQ-1:0][STAT_W-1:0] grant_q, grant_d;

  // Saturating counters; kill has no effect on them.
  always_comb begin
    stall_d = stall_q;
    grant_d = grant_q;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (req_valid[i] && !req_ready[i] && (stall_q[i] != '1)) begin
        stall_d[i] = stall_q[i] + STAT_W'(1);
      end
      if (pop[i] && (grant_q[i] != '1)) begin
        grant_d[i] = grant_q[i] + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
      grant_q <= '0;
    end else begin
      stall_q <= stall_d;
      grant_q <= grant_d;
    end
  end

  assign stall_cycles = stall_q;
  assign grant_cycles = grant_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the bus arbitration rules.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 2;
  localparam int CMP_W = 1 + 2 + $bits(EX_WR_PACKET) + N;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                kill = 1'b0;
  logic                resolve = 1'b0;
  EX_WR_PACKET [N-1:0] req_packet = '0;
  logic [N-1:0]        req_valid = '0;
  logic [N-1:0]        req_ready;
  EX_WR_PACKET         cdb_packet;
  logic                cdb_valid;
  logic [1:0]          cdb_src;
`ifdef CDB_ARB_STATS_EN
  logic [N-1:0][31:0]  stall_cycles;
  logic [N-1:0][31:0]  grant_cycles;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  EX_WR_PACKET mq [N][$];
  int          m_rr = 0;
  logic        m_valid = 1'b0;
  int          m_src = 0;
  EX_WR_PACKET m_pkt = '0;

  cdb_arbiter #(.N_REQ(N), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_packet(req_packet),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .kill      (kill),
    .resolve   (resolve),
    .cdb_packet(cdb_packet),
    .cdb_valid (cdb_valid),
    .cdb_src   (cdb_src)
`ifdef CDB_ARB_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .grant_cycles(grant_cycles)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (mq[i].size() < DEPTH);
    return r;
  endfunction

  function automatic logic [CMP_W-1:0] m_exp();
    return {m_valid, 2'(m_src), m_pkt, m_ready()};
  endfunction

  function automatic logic [CMP_W-1:0] dut_obs();
    return {cdb_valid, cdb_src, cdb_packet, req_ready};
  endfunction

  // One clock edge of the bus rules: kill, then grant, then push, then resolve.
  function automatic void model_step();
    logic [N-1:0] rdy;
    EX_WR_PACKET  keep [$];
    EX_WR_PACKET  t;
    int           w;
    if (reset) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_rr = 0; m_valid = 1'b0; m_pkt = '0; m_src = 0;
      return;
    end
    rdy = m_ready();
    if (kill) begin
      for (int i = 0; i < N; i++) begin
        keep.delete();
        foreach (mq[i][j]) if (!mq[i][j].speculative) keep.push_back(mq[i][j]);
        mq[i] = keep;
      end
    end
    w = -1;
    for (int k = 0; k < N; k++) begin
      if (w < 0 && mq[(m_rr + k) % N].size() > 0) w = (m_rr + k) % N;
    end
    if (w >= 0) begin
      m_pkt = mq[w].pop_front();
      m_pkt.valid = 1'b1;
      if (resolve) m_pkt.speculative = 1'b0;
      m_valid = 1'b1; m_src = w; m_rr = (w + 1) % N;
    end else begin
      m_valid = 1'b0; m_pkt = '0; m_src = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && rdy[i] && !(kill && req_packet[i].speculative))
        mq[i].push_back(req_packet[i]);
    end
    if (resolve) begin
      for (int i = 0; i < N; i++) begin
        foreach (mq[i][j]) begin
          t = mq[i][j]; t.speculative = 1'b0; mq[i][j] = t;
        end
      end
    end
  endfunction

  function automatic EX_WR_PACKET mk(input int tag, input int val, input logic spec);
    EX_WR_PACKET p;
    p.valid       = 1'($urandom);
    p.speculative = spec;
    p.rob_tag     = ROB_TAG_W'(tag);
    p.value       = DATA_W'(val);
    return p;
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; kill = 1'b0; resolve = 1'b0; req_valid = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    vectors++;
    if ({cdb_valid, cdb_src, cdb_packet} !== '0) begin
      miscompares++;
      $display("FAIL reset_out got %h exp 0", {cdb_valid, cdb_src, cdb_packet});
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (req_ready !== 4'hF || cdb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready got ready=%b valid=%b exp ready=1111 valid=0", req_ready, cdb_valid);
    end
  endtask

  task automatic test_single_push();
    req_packet[0] = mk(5, 32'h10, 1'b0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    vectors++;
    if (cdb_valid !== 1'b0 || req_ready !== 4'hF) begin
      miscompares++;
      $display("FAIL single_latency got valid=%b ready=%b exp valid=0 ready=1111", cdb_valid, req_ready);
    end
    tick();
    vectors++;
    if ({cdb_valid, cdb_src, cdb_packet.rob_tag, cdb_packet.value, cdb_packet.valid}
        !== {1'b1, 2'd0, 5'd5, 32'h10, 1'b1}) begin
      miscompares++;
      $display("FAIL single_out got v=%b src=%0d tag=%0d val=%h exp v=1 src=0 tag=5 val=10",
               cdb_valid, cdb_src, cdb_packet.rob_tag, cdb_packet.value);
    end
    vectors++;
    if (req_ready !== 4'hF) begin
      miscompares++;
      $display("FAIL single_ready got %b exp 1111", req_ready);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) req_packet[i] = mk(c * 4 + i, $urandom, 1'b0);
      req_valid = 4'hF;
      tick();
      if (c >= 1) begin
        vectors++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'((c - 1) % 4)) begin
          miscompares++;
          $display("FAIL fair_seq c=%0d got v=%b src=%0d exp v=1 src=%0d", c, cdb_valid, cdb_src, (c - 1) % 4);
        end
      end
      vectors++;
      if (dut_obs() !== m_exp()) begin
        miscompares++;
        $display("FAIL fair_model c=%0d got %h exp %h", c, dut_obs(), m_exp());
      end
    end
    req_valid = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if (dut_obs() !== m_exp()) begin
        miscompares++;
        $display("FAIL fair_drain c=%0d got %h exp %h", c, dut_obs(), m_exp());
      end
    end
  endtask

  task automatic test_backpressure();
    int           sent;
    int           got [$];
    logic         saw_block;
    logic [N-1:0] acc;
    do_reset();
    sent = 0; saw_block = 1'b0;
    for (int c = 0; c < 30 && got.size() < 3; c++) begin
      req_valid = '0;
      if (c < 10) begin
        req_valid[0] = 1'b1;
        req_packet[0] = mk(16 + c % 8, $urandom, 1'b0);
      end
      if (sent < 3) begin
        req_valid[2] = 1'b1;
        req_packet[2] = mk(21 + sent, $urandom, 1'b0);
      end
      acc = m_ready();
      if (sent == 2 && req_ready[2] === 1'b0) saw_block = 1'b1;
      tick();
      if (req_valid[2] && acc[2]) sent++;
      vectors++;
      if (dut_obs() !== m_exp()) begin
        miscompares++;
        $display("FAIL bp_model c=%0d got %h exp %h", c, dut_obs(), m_exp());
      end
      if (cdb_valid === 1'b1 && cdb_src === 2'd2) got.push_back(int'(cdb_packet.rob_tag));
    end
    req_valid = '0;
    vectors++;
    if (saw_block !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_block got %b exp 1", saw_block);
    end
    vectors++;
    if (got.size() != 3) begin
      miscompares++;
      $display("FAIL bp_count got %0d exp 3", got.size());
    end
    foreach (got[i]) begin
      vectors++;
      if (got[i] != 21 + i) begin
        miscompares++;
        $display("FAIL bp_order idx=%0d got %0d exp %0d", i, got[i], 21 + i);
      end
    end
    for (int c = 0; c < 6; c++) tick();
  endtask

  task automatic test_kill();
    logic bad;
    do_reset();
    req_packet[0] = mk(1, 32'hA1, 1'b0);
    req_packet[1] = mk(3, 32'hB3, 1'b1);
    req_valid = 4'b0011;
    tick();
    req_packet[0] = mk(2, 32'hA2, 1'b0);
    req_packet[1] = mk(4, 32'hB4, 1'b0);
    tick();
    vectors++;
    if ({cdb_valid, cdb_src, cdb_packet.rob_tag} !== {1'b1, 2'd0, 5'd1}) begin
      miscompares++;
      $display("FAIL kill_pre got v=%b src=%0d tag=%0d exp v=1 src=0 tag=1", cdb_valid, cdb_src, cdb_packet.rob_tag);
    end
    kill = 1'b1;
    req_packet[2] = mk(9, 32'hC9, 1'b1);
    req_valid = 4'b0100;
    tick();
    kill = 1'b0; req_valid = '0;
    vectors++;
    if ({cdb_valid, cdb_src, cdb_packet.rob_tag} !== {1'b1, 2'd1, 5'd4}) begin
      miscompares++;
      $display("FAIL kill_next got v=%b src=%0d tag=%0d exp v=1 src=1 tag=4", cdb_valid, cdb_src, cdb_packet.rob_tag);
    end
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (cdb_valid === 1'b1 && (cdb_packet.rob_tag === 5'd3 || cdb_packet.rob_tag === 5'd9)) bad = 1'b1;
      vectors++;
      if (dut_obs() !== m_exp()) begin
        miscompares++;
        $display("FAIL kill_model c=%0d got %h exp %h", c, dut_obs(), m_exp());
      end
    end
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("FAIL kill_leak got %b exp 0", bad);
    end
  endtask

  task automatic test_resolve();
    do_reset();
    req_packet[0] = mk(6, 32'h60, 1'b0);
    req_packet[1] = mk(20, 32'h200, 1'b0);
    req_valid = 4'b0011;
    tick();
    req_packet[0] = mk(7, 32'h70, 1'b1);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    resolve = 1'b1;
    tick();
    resolve = 1'b0;
    vectors++;
    if ({cdb_valid, cdb_src, cdb_packet.rob_tag} !== {1'b1, 2'd1, 5'd20}) begin
      miscompares++;
      $display("FAIL resolve_mid got v=%b src=%0d tag=%0d exp v=1 src=1 tag=20", cdb_valid, cdb_src, cdb_packet.rob_tag);
    end
    kill = 1'b1;
    tick();
    kill = 1'b0;
    vectors++;
    if ({cdb_valid, cdb_src, cdb_packet.rob_tag, cdb_packet.speculative} !== {1'b1, 2'd0, 5'd7, 1'b0}) begin
      miscompares++;
      $display("FAIL resolve_out got v=%b src=%0d tag=%0d spec=%b exp v=1 src=0 tag=7 spec=0",
               cdb_valid, cdb_src, cdb_packet.rob_tag, cdb_packet.speculative);
    end
    vectors++;
    if (dut_obs() !== m_exp()) begin
      miscompares++;
      $display("FAIL resolve_model got %h exp %h", dut_obs(), m_exp());
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 3; i++) req_packet[i] = mk(8 + c * 3 + i, $urandom, 1'b0);
      req_valid = 4'b0111;
      tick();
    end
    req_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (cdb_valid !== 1'b0 || req_ready !== 4'hF) begin
      miscompares++;
      $display("FAIL mid_reset got v=%b ready=%b exp v=0 ready=1111", cdb_valid, req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (cdb_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_quiet c=%0d got %b exp 0", c, cdb_valid);
      end
    end
    req_packet[0] = mk(12, 32'hC0, 1'b0);
    req_packet[3] = mk(13, 32'hC3, 1'b0);
    req_valid = 4'b1001;
    tick();
    req_valid = '0;
    tick();
    vectors++;
    if ({cdb_valid, cdb_src, cdb_packet.rob_tag} !== {1'b1, 2'd0, 5'd12}) begin
      miscompares++;
      $display("FAIL mid_rr0 got v=%b src=%0d tag=%0d exp v=1 src=0 tag=12", cdb_valid, cdb_src, cdb_packet.rob_tag);
    end
    tick();
    vectors++;
    if ({cdb_valid, cdb_src, cdb_packet.rob_tag} !== {1'b1, 2'd3, 5'd13}) begin
      miscompares++;
      $display("FAIL mid_rr3 got v=%b src=%0d tag=%0d exp v=1 src=3 tag=13", cdb_valid, cdb_src, cdb_packet.rob_tag);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      reset   = (($urandom % 100) == 0);
      kill    = (($urandom % 8) == 0);
      resolve = (($urandom % 6) == 0);
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) req_packet[i] = mk($urandom, $urandom, (($urandom % 3) == 0));
      tick();
      vectors++;
      if (dut_obs() !== m_exp()) begin
        miscompares++;
        $display("FAIL rand c=%0d got %h exp %h", c, dut_obs(), m_exp());
      end
    end
    idle_inputs();
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if (dut_obs() !== m_exp()) begin
        miscompares++;
        $display("FAIL rand_drain c=%0d got %h exp %h", c, dut_obs(), m_exp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fairness();
    test_backpressure();
    test_kill();
    test_resolve();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
